ltl_automata_engine: RTL

LTL_AUTOMATA_ENGINE -- requirements
Module: ltl_automata_engine

---
 rtl/ltl_automata_engine.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/ltl_automata_engine.sv
// ltl_automata_engine: homogeneous-automaton (STE) engine with a configurable
// match table and adjacency matrix, one symbol per step.
// Optional feature: define LTL_ENGINE_REPORT_CNT_EN to build sym_count and
// first_report_idx; otherwise both outputs are tied to zero.
module ltl_automata_engine #(
    parameter int N_STE = 9,
    parameter int SYM_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             run,
    input  logic             restart,
    input  logic             sym_valid,
    input  logic [SYM_W-1:0] symbols,
    input  logic             cfg_we,
    input  logic             cfg_edge_we,
    input  logic [4:0]       cfg_idx,
    input  logic [4:0]       cfg_src,
    input  logic [SYM_W-1:0] cfg_sym,
    input  logic             cfg_bit,
    input  logic [N_STE-1:0] start_sod_mask,
    input  logic [N_STE-1:0] start_all_mask,
    input  logic [N_STE-1:0] report_mask,
    output logic             cfg_err,
    output logic [N_STE-1:0] active_state,
    output logic [N_STE-1:0] report,
    output logic             report_any,
    output logic             report_sticky,
    output logic [CNT_W-1:0] sym_count,
    output logic [CNT_W-1:0] first_report_idx
);

    localparam int N_SYM = 2 ** SYM_W;

    logic [N_STE-1:0][N_SYM-1:0] match_q;
    logic [N_STE-1:0][N_STE-1:0] adj_q;     // adj_q[src][dst]
    logic [N_STE-1:0]            active_q;
    logic [N_STE-1:0]            nxt_active;
    logic [1:0]                  rst_sync_q;
    logic                        sod_q;
    logic                        sticky_q;
    logic                        cfg_err_q;
    logic                        step;
    logic                        rep_hit;
    logic                        idx_ok;
    logic                        src_ok;
    logic                        match_wr_ok;
    logic                        edge_wr_ok;

    assign step        = run & sym_valid & rst_sync_q[1];
    assign idx_ok      = {1'b0, cfg_idx} < 6'(N_STE);
    assign src_ok      = {1'b0, cfg_src} < 6'(N_STE);
    assign match_wr_ok = cfg_we & ~run & idx_ok;
    assign edge_wr_ok  = cfg_edge_we & ~run & idx_ok & src_ok;
    assign rep_hit     = |(nxt_active & report_mask);

    assign active_state  = active_q;
    assign report        = active_q & report_mask;
    assign report_any    = |report;
    assign report_sticky = sticky_q;
    assign cfg_err       = cfg_err_q;

    // Stretch reset release over two flops so stepping starts cleanly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= '0;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    // Next active vector: enabled-by-predecessor/start AND symbol match.
    always_comb begin
        logic en;
        nxt_active = '0;
        for (int unsigned j = 0; j < N_STE; j++) begin
            en = start_all_mask[j] | (start_sod_mask[j] & sod_q);
            for (int unsigned i = 0; i < N_STE; i++) begin
                en = en | (active_q[i] & adj_q[i][j]);
            end
            nxt_active[j] = match_q[j][symbols] & en;
        end
    end

    // Match table and adjacency writes, locked while running.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            match_q <= '0;
            adj_q   <= '0;
        end else begin
            for (int unsigned j = 0; j < N_STE; j++) begin
                if (match_wr_ok && cfg_idx == 5'(j)) match_q[j][cfg_sym] <= cfg_bit;
                for (int unsigned i = 0; i < N_STE; i++) begin
                    if (edge_wr_ok && cfg_src == 5'(i) && cfg_idx == 5'(j))
                        adj_q[i][j] <= cfg_bit;
                end
            end
        end
    end

    // One-cycle error pulse for any requested write that gets dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cfg_err_q <= 1'b0;
        else          cfg_err_q <= (cfg_we & ~match_wr_ok) | (cfg_edge_we & ~edge_wr_ok);
    end

    // Active set, start-of-data flag and sticky report; restart beats a step.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_q <= '0;
            sod_q    <= 1'b1;
            sticky_q <= 1'b0;
        end else if (restart) begin
            active_q <= '0;
            sod_q    <= 1'b1;
            sticky_q <= 1'b0;
        end else if (step) begin
            active_q <= nxt_active;
            sod_q    <= 1'b0;
            if (rep_hit) sticky_q <= 1'b1;
        end
    end

`ifdef LTL_ENGINE_REPORT_CNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] first_q;
    logic [CNT_W-1:0] cnt_nxt;

    assign cnt_nxt          = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    assign sym_count        = cnt_q;
    assign first_report_idx = first_q;

    // Saturating symbol counter; first report index captures the post-step count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            first_q <= '0;
        end else if (restart) begin
            cnt_q   <= '0;
            first_q <= '0;
        end else if (step) begin
            cnt_q <= cnt_nxt;
            if (rep_hit && !sticky_q) first_q <= cnt_nxt;
        end
    end
`else
    assign sym_count        = '0;
    assign first_report_idx = '0;
`endif

endmodule
